multicycle_control: RTL and testbench

Multicycle MIPS control unit: a Moore finite-state machine that sequences each instruction over 3–5 clock cycles, sharing one ALU and one memory port. It generates every datapath enable and mux select, plus the ALU control code. It replaces the single-cycle control path in the multicycle processor variant and adds `bne`, `addi` and `j`. Opcode/funct widths, ALU control width and optional instructions are parametrised.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_alu_decode.sv | 33 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BEQ    = 4'd8,
        ST_BNE    = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decoder: maps the FSM's ALUOp and the instruction funct field
// to the ALU operation code, zero-extended (or truncated) to ALUCTRL_W.
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           i_alu_op,
    input  logic [FUNCT_W-1:0]   i_func,
    output logic [ALUCTRL_W-1:0] o_alu_control
);

    logic [3:0] w_code;

    // NOTE: w_code gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        w_code = ALU_ADD;
        if (i_alu_op == ALUOP_SUB) begin
            w_code = ALU_SUB;
        end else if (i_alu_op == ALUOP_FUNCT) begin
            if (i_func == FUNCT_W'(FN_ADD))      w_code = ALU_ADD;
            else if (i_func == FUNCT_W'(FN_SUB)) w_code = ALU_SUB;
            else if (i_func == FUNCT_W'(FN_AND)) w_code = ALU_AND;
            else if (i_func == FUNCT_W'(FN_OR))  w_code = ALU_OR;
            else if (i_func == FUNCT_W'(FN_SLT)) w_code = ALU_SLT;
            else                                 w_code = ALU_ADD;
        end
    end

    assign o_alu_control = ALUCTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over
// 3-5 cycles and decoding every datapath enable/select from the current state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 4,
    parameter int EN_BNE    = 1,
    parameter int EN_JUMP   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      Opcode,
    input  logic [FUNCT_W-1:0]   Func,
    input  logic                 Zero,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCEn,
    output logic [1:0]           PCSrc,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [3:0]           State
);

    state_t  r_state;

    logic    w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_addi, w_is_j;
    logic    w_legal;
    logic    w_iord, w_mem_write, w_ir_write, w_pc_write, w_branch, w_branch_ne;
    logic    w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
    logic    w_illegal;
    logic [1:0] w_pc_src, w_alu_src_b;
    alu_op_t w_alu_op;

    assign w_is_r    = (Opcode == OP_W'(OP_RTYPE));
    assign w_is_lw   = (Opcode == OP_W'(OP_LW));
    assign w_is_sw   = (Opcode == OP_W'(OP_SW));
    assign w_is_beq  = (Opcode == OP_W'(OP_BEQ));
    assign w_is_bne  = (EN_BNE != 0) && (Opcode == OP_W'(OP_BNE));
    assign w_is_addi = (Opcode == OP_W'(OP_ADDI));
    assign w_is_j    = (EN_JUMP != 0) && (Opcode == OP_W'(OP_J));
    assign w_legal   = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_bne | w_is_addi | w_is_j;

    // NOTE: state is sequential, so it is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (w_is_lw || w_is_sw) r_state <= ST_MEMADR;
                    else if (w_is_r)        r_state <= ST_EXEC;
                    else if (w_is_beq)      r_state <= ST_BEQ;
                    else if (w_is_bne)      r_state <= ST_BNE;
                    else if (w_is_addi)     r_state <= ST_ADDIEX;
                    else if (w_is_j)        r_state <= ST_JUMP;
                    else                    r_state <= ST_FETCH;
                end
                ST_MEMADR: r_state <= w_is_lw ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD:  r_state <= ST_MEMWB;
                ST_EXEC:   r_state <= ST_ALUWB;
                ST_ADDIEX: r_state <= ST_ADDIWB;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_pc_src     = PCSRC_ALU;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_B;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            ST_FETCH: begin
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            ST_DECODE: w_alu_src_b = SRCB_IMM_SH2;
            ST_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            ST_MEMRD:  w_iord = 1'b1;
            ST_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            ST_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALUOP_SUB;
                w_pc_src    = PCSRC_ALUOUT;
                w_branch    = (r_state == ST_BEQ);
                w_branch_ne = (r_state == ST_BNE);
            end
            ST_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            ST_ADDIWB: w_reg_write = 1'b1;
            ST_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_illegal = (r_state == ST_DECODE) && !w_legal;

    // Side-effecting enables are held off while reset is asserted; state is already FETCH.
    assign IRWrite    = ~reset & w_ir_write;
    assign MemWrite   = ~reset & w_mem_write;
    assign RegWrite   = ~reset & w_reg_write;
    assign Illegal    = ~reset & w_illegal;
    assign PCEn       = ~reset & (w_pc_write | (w_branch & Zero) | (w_branch_ne & ~Zero));
    assign IorD       = w_iord;
    assign PCSrc      = w_pc_src;
    assign RegDst     = w_reg_dst;
    assign MemtoReg   = w_mem_to_reg;
    assign ALUSrcA    = w_alu_src_a;
    assign ALUSrcB    = w_alu_src_b;
    assign State      = r_state;

    mc_alu_decode #(
        .FUNCT_W   (FUNCT_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decode (
        .i_alu_op      (w_alu_op),
        .i_func        (Func),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected output
// vectors are queued with each instruction and compared as the FSM advances.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       iord, mem_write, ir_write, pc_en;
        logic [1:0] pc_src;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       illegal;
    } vec_t;

    typedef struct packed {
        logic sel;
        vec_t e;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Func;
    logic       Zero;

    logic       iord0, mw0, irw0, pcen0, rdst0, m2r0, rw0, srca0, ill0;
    logic [1:0] pcsrc0, srcb0;
    logic [3:0] aluc0, st0;
    logic       iord1, mw1, irw1, pcen1, rdst1, m2r1, rw1, srca1, ill1;
    logic [1:0] pcsrc1, srcb1;
    logic [3:0] aluc1, st1;
    vec_t       obs0, obs1;

    item_t      sb[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Func(Func), .Zero(Zero),
        .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .PCEn(pcen0), .PCSrc(pcsrc0),
        .RegDst(rdst0), .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(srca0),
        .ALUSrcB(srcb0), .ALUControl(aluc0), .Illegal(ill0), .State(st0)
    );

    multicycle_control #(.EN_BNE(0)) dut_nobne (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Func(Func), .Zero(Zero),
        .IorD(iord1), .MemWrite(mw1), .IRWrite(irw1), .PCEn(pcen1), .PCSrc(pcsrc1),
        .RegDst(rdst1), .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(srca1),
        .ALUSrcB(srcb1), .ALUControl(aluc1), .Illegal(ill1), .State(st1)
    );

    assign obs0 = {st0, iord0, mw0, irw0, pcen0, pcsrc0, rdst0, m2r0, rw0, srca0, srcb0, aluc0, ill0};
    assign obs1 = {st1, iord1, mw1, irw1, pcen1, pcsrc1, rdst1, m2r1, rw1, srca1, srcb1, aluc1, ill1};

    // Reference table of Moore outputs per state; in_rst applies the reset gating.
    function automatic vec_t exp_of(input state_t st, input logic z, input logic [3:0] alu,
                                    input logic ill, input logic in_rst);
        vec_t e;
        e             = '0;
        e.state       = st;
        e.alu_control = 4'b0010;
        case (st)
            ST_FETCH:  begin e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1; end
            ST_DECODE: begin e.alu_src_b = 2'b11; e.illegal = ill; end
            ST_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_MEMRD:  e.iord = 1'b1;
            ST_MEMWB:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            ST_MEMWR:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
            ST_EXEC:   begin e.alu_src_a = 1'b1; e.alu_control = alu; end
            ST_ALUWB:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            ST_BEQ:    begin e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01; e.pc_en = z; end
            ST_BNE:    begin e.alu_src_a = 1'b1; e.alu_control = 4'b0110; e.pc_src = 2'b01; e.pc_en = ~z; end
            ST_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_ADDIWB: e.reg_write = 1'b1;
            ST_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
            default: ;
        endcase
        if (in_rst) begin
            e.ir_write  = 1'b0;
            e.pc_en     = 1'b0;
            e.mem_write = 1'b0;
            e.reg_write = 1'b0;
            e.illegal   = 1'b0;
        end
        return e;
    endfunction

    task automatic push(input logic sel, input state_t st, input logic [3:0] alu,
                        input logic ill, input logic in_rst);
        item_t it;
        it.sel = sel;
        it.e   = exp_of(st, Zero, alu, ill, in_rst);
        sb.push_back(it);
    endtask

    task automatic check_now(input string tag);
        item_t it;
        vec_t  obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h required an expected entry", tag, obs0);
        end else begin
            it  = sb.pop_front();
            obs = it.sel ? obs1 : obs0;
            assert (obs === it.e) else begin
                errors++;
                $error("FAIL %s: got %h required %h (state got %0d required %0d)",
                       tag, obs, it.e, obs.state, it.e.state);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_now(tag);
            step();
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Opcode = op;
        Func   = fn;
        Zero   = z;
        #1;
    endtask

    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [3:0] alu_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b0010};

    initial begin
        reset  = 1'b0;
        Opcode = 6'b0;
        Func   = 6'b0;
        Zero   = 1'b0;
        #1 reset = 1'b1;
        #1;
        push(0, ST_FETCH, 4'b0, 0, 1); check_now("reset_t0");
        step(); push(0, ST_FETCH, 4'b0, 0, 1); check_now("reset_c1");
        step(); push(0, ST_FETCH, 4'b0, 0, 1); check_now("reset_c2");
        @(negedge clk);
        reset = 1'b0;

        // lw with Zero high: Zero must not disturb non-branch states.
        drive(6'b100011, 6'b0, 1'b1);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0); push(0, ST_MEMADR, 0, 0, 0);
        push(0, ST_MEMRD, 0, 0, 0); push(0, ST_MEMWB, 0, 0, 0);
        run("lw", 5);

        for (int i = 0; i < 6; i++) begin
            drive(6'b000000, fn_tab[i], 1'b0);
            push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0);
            push(0, ST_EXEC, alu_tab[i], 0, 0); push(0, ST_ALUWB, 0, 0, 0);
            run("rtype", 4);
        end

        drive(6'b101011, 6'b0, 1'b0);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0);
        push(0, ST_MEMADR, 0, 0, 0); push(0, ST_MEMWR, 0, 0, 0);
        run("sw", 4);

        for (int z = 1; z >= 0; z--) begin
            drive(6'b000100, 6'b0, z[0]);
            push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0); push(0, ST_BEQ, 0, 0, 0);
            run("beq", 3);
            drive(6'b000101, 6'b0, z[0]);
            push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0); push(0, ST_BNE, 0, 0, 0);
            run("bne", 3);
        end

        drive(6'b000010, 6'b0, 1'b0);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0); push(0, ST_JUMP, 0, 0, 0);
        run("j", 3);

        drive(6'b001000, 6'b0, 1'b1);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0);
        push(0, ST_ADDIEX, 0, 0, 0); push(0, ST_ADDIWB, 0, 0, 0);
        run("addi", 4);

        drive(6'b111111, 6'b0, 1'b0);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 1, 0);
        run("illegal", 2);

        // lw abandoned by a reset raised between edges while in MEMRD.
        drive(6'b100011, 6'b0, 1'b0);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0);
        push(0, ST_MEMADR, 0, 0, 0); push(0, ST_MEMRD, 0, 0, 0);
        run("lw_pre_rst", 3);
        check_now("lw_memrd");
        #2 reset = 1'b1;
        #1;
        push(0, ST_FETCH, 0, 0, 1); check_now("async_rst");
        step(); push(0, ST_FETCH, 0, 0, 1); check_now("rst_hold1");
        step(); push(0, ST_FETCH, 0, 0, 1); check_now("rst_hold2");
        @(negedge clk);
        reset = 1'b0;

        drive(6'b000000, 6'b100000, 1'b0);
        push(0, ST_FETCH, 0, 0, 0); push(0, ST_DECODE, 0, 0, 0);
        push(0, ST_EXEC, 4'b0010, 0, 0); push(0, ST_ALUWB, 0, 0, 0);
        push(0, ST_FETCH, 0, 0, 0);
        run("post_rst_add", 5);

        // Resynchronise both instances, then bne must be illegal on the EN_BNE=0 one.
        reset = 1'b1;
        step();
        @(negedge clk);
        reset = 1'b0;
        drive(6'b000101, 6'b0, 1'b0);
        push(1, ST_FETCH, 0, 0, 0); push(1, ST_DECODE, 0, 1, 0); push(1, ST_FETCH, 0, 0, 0);
        run("nobne_bne", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
